// File: rtl/fb_pkg.sv
// Shared definitions for the frame writer slice.
//   fw_state_t     : writer FSM states (IDLE, WRITE, WAIT_SWAP)
//   FB_H_ACTIVE    : default visible width
//   FB_V_ACTIVE    : default visible height
//   FB_PIX_W       : framebuffer word width (24, or 16 with FRAME_WRITER_RGB565_EN)
//   rgb888_to_565  : packs {R,G,B} 8:8:8 into 5:6:5
// Optional feature macro: FRAME_WRITER_RGB565_EN
package fb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITE     = 2'd1,
      WAIT_SWAP = 2'd2
   } fw_state_t;

   localparam int FB_H_ACTIVE = 320;
   localparam int FB_V_ACTIVE = 180;

`ifdef FRAME_WRITER_RGB565_EN
   localparam int FB_PIX_W = 16;
`else
   localparam int FB_PIX_W = 24;
`endif

   function automatic logic [15:0] rgb888_to_565(input logic [23:0] pix);
      return {pix[23:19], pix[15:10], pix[7:3]};
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Two-stage registered framebuffer address/data generator.
//   S1 registers the pixel, column, row*H_ACTIVE, the target bank, the
//   in-range flag and the final-coordinate flag. S2 forms the bank-offset
//   address and drives the write strobe.
// Ports:
//   aclk, aresetn  : clock, asynchronous active-low reset
//   valid_i        : pixel accepted this cycle
//   pixel_i        : RGB888 pixel {R,G,B}
//   h_i, v_i       : pixel coordinates
//   bank_i         : bank to write, latched with the pixel at S1
//   fb_addr_o      : framebuffer address (S2)
//   fb_wdata_o     : framebuffer data (S2)
//   fb_we_o        : write strobe (S2)
//   last_o         : final-coordinate pixel written this cycle (S2)
//   drop_o         : out-of-range pixel leaving S1 (counted at S2)
// Optional feature macro: FRAME_WRITER_RGB565_EN (packs data to RGB565).
module fb_addr_gen
   import fb_pkg::*;
#(
   parameter int H_ACTIVE = FB_H_ACTIVE,
   parameter int V_ACTIVE = FB_V_ACTIVE,
   parameter int ADDR_W   = $clog2(2 * H_ACTIVE * V_ACTIVE)
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                valid_i,
   input  logic [23:0]         pixel_i,
   input  logic [10:0]         h_i,
   input  logic [9:0]          v_i,
   input  logic                bank_i,
   output logic [ADDR_W-1:0]   fb_addr_o,
   output logic [FB_PIX_W-1:0] fb_wdata_o,
   output logic                fb_we_o,
   output logic                last_o,
   output logic                drop_o
);

   localparam logic [10:0]       H_LIM    = 11'(H_ACTIVE);
   localparam logic [9:0]        V_LIM    = 10'(V_ACTIVE);
   localparam logic [10:0]       H_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [9:0]        V_LAST   = 10'(V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] BANK_OFF = ADDR_W'(H_ACTIVE * V_ACTIVE);

   // S1 state
   logic              s1_valid_q;
   logic [23:0]       s1_pix_q;
   logic [10:0]       s1_h_q;
   logic [ADDR_W-1:0] s1_vmul_q;
   logic              s1_in_range_q;
   logic              s1_last_q;
   logic              s1_bank_q;

   // S2 state
   logic [ADDR_W-1:0]   s2_addr_q;
   logic [FB_PIX_W-1:0] s2_wdata_q;
   logic                s2_we_q;
   logic                s2_last_q;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would let S2 see this cycle's S1 update.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s1_valid_q    <= 1'b0;
         s1_pix_q      <= '0;
         s1_h_q        <= '0;
         s1_vmul_q     <= '0;
         s1_in_range_q <= 1'b0;
         s1_last_q     <= 1'b0;
         s1_bank_q     <= 1'b0;
         s2_addr_q     <= '0;
         s2_wdata_q    <= '0;
         s2_we_q       <= 1'b0;
         s2_last_q     <= 1'b0;
      end else begin
         s1_valid_q <= valid_i;
         if (valid_i) begin
            s1_pix_q      <= pixel_i;
            s1_h_q        <= h_i;
            s1_vmul_q     <= ADDR_W'(v_i) * ADDR_W'(H_ACTIVE);
            s1_in_range_q <= (h_i < H_LIM) && (v_i < V_LIM);
            s1_last_q     <= (h_i == H_LAST) && (v_i == V_LAST);
            s1_bank_q     <= bank_i;
         end

         s2_we_q   <= s1_valid_q & s1_in_range_q;
         s2_last_q <= s1_valid_q & s1_last_q;
         // Address/data only move on a real write so the port holds steady otherwise.
         if (s1_valid_q && s1_in_range_q) begin
            s2_addr_q <= (s1_bank_q ? BANK_OFF : '0) + s1_vmul_q + ADDR_W'(s1_h_q);
`ifdef FRAME_WRITER_RGB565_EN
            s2_wdata_q <= rgb888_to_565(s1_pix_q);
`else
            s2_wdata_q <= s1_pix_q;
`endif
         end
      end
   end

   assign fb_addr_o  = s2_addr_q;
   assign fb_wdata_o = s2_wdata_q;
   assign fb_we_o    = s2_we_q;
   assign last_o     = s2_last_q;
   assign drop_o     = s1_valid_q & ~s1_in_range_q;

endmodule

// File: rtl/frame_writer.sv
// Frame writer: pixel AXI-stream sink writing a double-buffered framebuffer.
// Accepts pixels in WRITE, turns each into a BRAM write two cycles later,
// pulses frame_done with the final pixel's write, then holds off the stream
// in WAIT_SWAP until the display side acknowledges the bank swap.
// Ports:
//   aclk, aresetn        : clock, asynchronous active-low reset
//   start                : arms writing from IDLE (ignored elsewhere)
//   pixel_axis_*         : RGB888 pixel stream {R,G,B}
//   hcount_in, vcount_in : coordinates travelling with each pixel
//   fb_addr/wdata/we     : framebuffer write port
//   write_bank           : bank currently targeted by new pixels
//   frame_done           : one-cycle pulse with the final pixel's write
//   swap_ack             : display has switched to the completed bank
//   drop_count           : saturating count of out-of-range pixels this frame
// Optional feature macro: FRAME_WRITER_RGB565_EN (16-bit RGB565 framebuffer).
module frame_writer
   import fb_pkg::*;
#(
   parameter int H_ACTIVE = FB_H_ACTIVE,
   parameter int V_ACTIVE = FB_V_ACTIVE,
   parameter int ADDR_W   = $clog2(2 * H_ACTIVE * V_ACTIVE)
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                start,
   input  logic [23:0]         pixel_axis_tdata,
   input  logic                pixel_axis_tvalid,
   output logic                pixel_axis_tready,
   input  logic [10:0]         hcount_in,
   input  logic [9:0]          vcount_in,
   output logic [ADDR_W-1:0]   fb_addr,
   output logic [FB_PIX_W-1:0] fb_wdata,
   output logic                fb_we,
   output logic                write_bank,
   output logic                frame_done,
   input  logic                swap_ack,
   output logic [15:0]         drop_count
);

   localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

   fw_state_t   state_q;
   logic        tready_q;
   logic        bank_q;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        accept;
   logic        last_in;
   logic        drop_pulse;
   logic        drop_clear;

   assign accept  = pixel_axis_tvalid & tready_q;
   assign last_in = (hcount_in == H_LAST) && (vcount_in == V_LAST);

   // Counter clears on a new frame; a clear wins over a coincident drop.
   assign drop_clear = ((state_q == IDLE) && start) ||
                       ((state_q == WAIT_SWAP) && swap_ack);

   // NOTE: an always_comb must assign every output on every path; the
   // default first line is what keeps this from becoming a latch.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_clear) begin
         drop_cnt_d = '0;
      end else if (drop_pulse && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // tready is registered alongside the state so it changes with the state.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         tready_q   <= 1'b0;
         bank_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q  <= WRITE;
                  tready_q <= 1'b1;
               end
            end
            WRITE: begin
               // Any final-coordinate pixel ends the frame; order is not assumed.
               if (accept && last_in) begin
                  state_q  <= WAIT_SWAP;
                  tready_q <= 1'b0;
               end
            end
            WAIT_SWAP: begin
               if (swap_ack) begin
                  bank_q   <= ~bank_q;
                  state_q  <= WRITE;
                  tready_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               tready_q <= 1'b0;
            end
         endcase
      end
   end

   fb_addr_gen #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .ADDR_W   (ADDR_W)
   ) u_addr_gen (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .valid_i    (accept),
      .pixel_i    (pixel_axis_tdata),
      .h_i        (hcount_in),
      .v_i        (vcount_in),
      .bank_i     (bank_q),
      .fb_addr_o  (fb_addr),
      .fb_wdata_o (fb_wdata),
      .fb_we_o    (fb_we),
      .last_o     (frame_done),
      .drop_o     (drop_pulse)
   );

   assign pixel_axis_tready = tready_q;
   assign write_bank        = bank_q;
   assign drop_count        = drop_cnt_q;

endmodule
